// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolver: detects mispredicts against the fetch-time BTB
// prediction, issues a one-cycle redirect/flush and queues BTB update requests.
// Define BRU_PERF_CNT_EN to build the saturating branch/mispredict counters.
module branch_resolve_unit #(
  parameter int PC_WIDTH   = 32,
  parameter int QDEPTH     = 4,
  parameter int QPTR_WIDTH = 2,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ex_valid,
  input  logic [PC_WIDTH-1:0]  ex_pc,
  input  logic                 ex_is_branch,
  input  logic                 ex_taken,
  input  logic [PC_WIDTH-1:0]  ex_target,
  input  logic                 ex_pred_hit,
  input  logic [PC_WIDTH-1:0]  ex_pred_target,
  output logic                 redirect_valid,
  output logic [PC_WIDTH-1:0]  redirect_pc,
  output logic                 flush,
  output logic                 upd_valid,
  output logic [PC_WIDTH-1:0]  upd_pc,
  output logic [PC_WIDTH-1:0]  upd_target,
  input  logic                 upd_ready,
  output logic                 q_full,
  output logic                 q_overflow,
  output logic [CNT_WIDTH-1:0] br_count,
  output logic [CNT_WIDTH-1:0] mispred_count
);

  localparam int CW = QPTR_WIDTH + 1;

  // ---------------------------------------------------------------------------
  // Resolution
  // ---------------------------------------------------------------------------
  logic                accept;
  logic                taken_miss;
  logic                nt_miss;
  logic                alias_miss;
  logic                mispredict;
  logic                enq_req;
  logic [PC_WIDTH-1:0] seq_pc;
  logic [PC_WIDTH-1:0] redirect_pc_next;

  // The instruction in EX during a redirect cycle is wrong-path and is ignored.
  assign accept     = ex_valid & ~redirect_valid;
  assign taken_miss = ex_is_branch & ex_taken &
                      (~ex_pred_hit | (ex_pred_target != ex_target));
  assign nt_miss    = ex_is_branch & ~ex_taken & ex_pred_hit;
  assign alias_miss = ~ex_is_branch & ex_pred_hit;
  assign mispredict = accept & (taken_miss | nt_miss | alias_miss);
  assign enq_req    = accept & taken_miss;

  assign seq_pc           = ex_pc + PC_WIDTH'(4);
  assign redirect_pc_next = taken_miss ? ex_target : seq_pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      redirect_valid <= mispredict;
      if (mispredict) begin
        redirect_pc <= redirect_pc_next;
      end
    end
  end

  assign flush = redirect_valid;

  // ---------------------------------------------------------------------------
  // BTB update queue
  // upd_valid/upd_ready: an entry transfers on each rising edge where both are
  // high; upd_valid never depends on upd_ready and the head holds until taken.
  // ---------------------------------------------------------------------------
  logic [PC_WIDTH-1:0]   pc_mem  [QDEPTH];
  logic [PC_WIDTH-1:0]   tgt_mem [QDEPTH];
  logic [QPTR_WIDTH-1:0] wr_ptr;
  logic [QPTR_WIDTH-1:0] rd_ptr;
  logic [CW-1:0]         q_count;
  logic                  deq;
  logic                  enq_ok;
  logic                  enq_drop;

  assign upd_valid  = (q_count != '0);
  assign q_full     = (q_count == CW'(QDEPTH));
  assign deq        = upd_valid & upd_ready;
  // A full queue still accepts when the head leaves in the same cycle.
  assign enq_ok     = enq_req & (~q_full | deq);
  assign enq_drop   = enq_req & q_full & ~deq;
  assign upd_pc     = pc_mem[rd_ptr];
  assign upd_target = tgt_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (enq_ok) begin
      pc_mem[wr_ptr]  <= ex_pc;
      tgt_mem[wr_ptr] <= ex_target;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      q_count    <= '0;
      q_overflow <= 1'b0;
    end else begin
      if (enq_ok) begin
        wr_ptr <= wr_ptr + QPTR_WIDTH'(1);
      end
      if (deq) begin
        rd_ptr <= rd_ptr + QPTR_WIDTH'(1);
      end
      if (enq_ok && !deq) begin
        q_count <= q_count + CW'(1);
      end else if (deq && !enq_ok) begin
        q_count <= q_count - CW'(1);
      end
      if (enq_drop) begin
        q_overflow <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Performance counters
  // ---------------------------------------------------------------------------
`ifdef BRU_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] br_cnt_q;
  logic [CNT_WIDTH-1:0] mis_cnt_q;

  // Both counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else begin
      if (accept && ex_is_branch && !(&br_cnt_q)) begin
        br_cnt_q <= br_cnt_q + CNT_WIDTH'(1);
      end
      if (mispredict && !(&mis_cnt_q)) begin
        mis_cnt_q <= mis_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  assign br_count      = br_cnt_q;
  assign mispred_count = mis_cnt_q;
`else
  assign br_count      = '0;
  assign mispred_count = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed scenarios plus a
// randomized run, all checked against a queue-based reference model.
module tb_branch_resolve_unit;

  localparam int PC_WIDTH   = 32;
  localparam int QDEPTH     = 4;
  localparam int QPTR_WIDTH = 2;
  localparam int CNT_WIDTH  = 32;
`ifdef BRU_PERF_CNT_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic                 ex_valid = 1'b0;
  logic [PC_WIDTH-1:0]  ex_pc = '0;
  logic                 ex_is_branch = 1'b0;
  logic                 ex_taken = 1'b0;
  logic [PC_WIDTH-1:0]  ex_target = '0;
  logic                 ex_pred_hit = 1'b0;
  logic [PC_WIDTH-1:0]  ex_pred_target = '0;
  logic                 redirect_valid;
  logic [PC_WIDTH-1:0]  redirect_pc;
  logic                 flush;
  logic                 upd_valid;
  logic [PC_WIDTH-1:0]  upd_pc;
  logic [PC_WIDTH-1:0]  upd_target;
  logic                 upd_ready = 1'b0;
  logic                 q_full;
  logic                 q_overflow;
  logic [CNT_WIDTH-1:0] br_count;
  logic [CNT_WIDTH-1:0] mispred_count;

  branch_resolve_unit #(
    .PC_WIDTH(PC_WIDTH), .QDEPTH(QDEPTH), .QPTR_WIDTH(QPTR_WIDTH), .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clk(clk), .reset(reset),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_is_branch(ex_is_branch), .ex_taken(ex_taken),
    .ex_target(ex_target), .ex_pred_hit(ex_pred_hit), .ex_pred_target(ex_pred_target),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target), .upd_ready(upd_ready),
    .q_full(q_full), .q_overflow(q_overflow),
    .br_count(br_count), .mispred_count(mispred_count)
  );

  // ---------------- reference model / scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [2*PC_WIDTH-1:0] exp_q[$];
  logic                  m_rv  = 1'b0;
  logic [PC_WIDTH-1:0]   m_rpc = '0;
  logic                  m_ovf = 1'b0;
  logic [CNT_WIDTH-1:0]  m_br  = '0;
  logic [CNT_WIDTH-1:0]  m_mis = '0;

  task automatic model_reset();
    exp_q.delete();
    m_rv = 1'b0; m_rpc = '0; m_ovf = 1'b0; m_br = '0; m_mis = '0;
  endtask

  // One rising edge worth of behaviour, from the inputs present at that edge.
  task automatic model_step();
    bit accept, mis, enq, deq;
    logic [PC_WIDTH-1:0] npc;
    accept = ex_valid && !m_rv;
    deq    = (exp_q.size() != 0) && upd_ready;
    mis = 1'b0; enq = 1'b0; npc = ex_pc + 32'd4;
    if (accept) begin
      if (ex_is_branch && ex_taken && (!ex_pred_hit || ex_pred_target != ex_target)) begin
        mis = 1'b1; enq = 1'b1; npc = ex_target;
      end else if (ex_pred_hit && !(ex_is_branch && ex_taken)) begin
        mis = 1'b1;
      end
    end
    if (deq) void'(exp_q.pop_front());
    if (enq) begin
      if (exp_q.size() < QDEPTH) exp_q.push_back({ex_pc, ex_target});
      else m_ovf = 1'b1;
    end
    if (PERF_EN) begin
      if (accept && ex_is_branch && m_br != '1) m_br = m_br + 1;
      if (mis && m_mis != '1) m_mis = m_mis + 1;
    end
    m_rv = mis;
    if (mis) m_rpc = npc;
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic drive(input logic [31:0] pc, input logic isb, input logic tk,
                       input logic [31:0] tgt, input logic ph, input logic [31:0] pt);
    ex_valid = 1'b1; ex_pc = pc; ex_is_branch = isb; ex_taken = tk;
    ex_target = tgt; ex_pred_hit = ph; ex_pred_target = pt;
  endtask

  task automatic idle();
    ex_valid = 1'b0; ex_pc = '0; ex_is_branch = 1'b0; ex_taken = 1'b0;
    ex_target = '0; ex_pred_hit = 1'b0; ex_pred_target = '0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1; idle(); upd_ready = 1'b0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    apply_reset();
    n_checks++; if (redirect_valid !== 1'b0) $display("FAIL reset_redirect_valid got %0b exp 0", redirect_valid); else n_pass++;
    n_checks++; if (redirect_pc !== 32'h0) $display("FAIL reset_redirect_pc got %h exp 0", redirect_pc); else n_pass++;
    n_checks++; if (flush !== 1'b0) $display("FAIL reset_flush got %0b exp 0", flush); else n_pass++;
    n_checks++; if (upd_valid !== 1'b0) $display("FAIL reset_upd_valid got %0b exp 0", upd_valid); else n_pass++;
    n_checks++; if (q_full !== 1'b0) $display("FAIL reset_q_full got %0b exp 0", q_full); else n_pass++;
    n_checks++; if (q_overflow !== 1'b0) $display("FAIL reset_q_overflow got %0b exp 0", q_overflow); else n_pass++;
    n_checks++; if (br_count !== '0) $display("FAIL reset_br_count got %0d exp 0", br_count); else n_pass++;
    n_checks++; if (mispred_count !== '0) $display("FAIL reset_mispred_count got %0d exp 0", mispred_count); else n_pass++;
  endtask

  task automatic test_cold_miss();
    upd_ready = 1'b1;
    drive(32'h100, 1'b1, 1'b1, 32'h200, 1'b0, 32'h0);
    cycle();
    idle();
    n_checks++; if (redirect_valid !== 1'b1) $display("FAIL cold_redirect_valid got %0b exp 1", redirect_valid); else n_pass++;
    n_checks++; if (flush !== 1'b1) $display("FAIL cold_flush got %0b exp 1", flush); else n_pass++;
    n_checks++; if (redirect_pc !== 32'h200) $display("FAIL cold_redirect_pc got %h exp 200", redirect_pc); else n_pass++;
    n_checks++; if (upd_valid !== 1'b1) $display("FAIL cold_upd_valid got %0b exp 1", upd_valid); else n_pass++;
    n_checks++; if (upd_pc !== 32'h100 || upd_target !== 32'h200) $display("FAIL cold_upd_entry got %h/%h exp 100/200", upd_pc, upd_target); else n_pass++;
    cycle();
    n_checks++; if (upd_valid !== 1'b0) $display("FAIL cold_drain got upd_valid %0b exp 0", upd_valid); else n_pass++;
    n_checks++; if (redirect_valid !== 1'b0 || flush !== 1'b0) $display("FAIL cold_pulse_len got %0b/%0b exp 0/0", redirect_valid, flush); else n_pass++;
  endtask

  task automatic test_wrong_target();
    upd_ready = 1'b1;
    drive(32'h100, 1'b1, 1'b1, 32'h200, 1'b1, 32'h300);
    cycle();
    idle();
    n_checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h200) $display("FAIL wt_redirect got %0b/%h exp 1/200", redirect_valid, redirect_pc); else n_pass++;
    n_checks++; if (upd_valid !== 1'b1 || upd_pc !== 32'h100 || upd_target !== 32'h200) $display("FAIL wt_enqueue got %0b %h/%h exp 1 100/200", upd_valid, upd_pc, upd_target); else n_pass++;
    cycle();
    drive(32'h100, 1'b1, 1'b1, 32'h200, 1'b1, 32'h200);
    cycle();
    idle();
    n_checks++; if (redirect_valid !== 1'b0) $display("FAIL wt_hit_redirect got %0b exp 0", redirect_valid); else n_pass++;
    n_checks++; if (upd_valid !== 1'b0) $display("FAIL wt_hit_enqueue got %0b exp 0", upd_valid); else n_pass++;
    cycle();
  endtask

  task automatic test_wrap();
    upd_ready = 1'b1;
    drive(32'hFFFF_FFFC, 1'b1, 1'b0, 32'h1234, 1'b1, 32'h1234);
    cycle();
    idle();
    n_checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h0) $display("FAIL wrap_redirect got %0b/%h exp 1/00000000", redirect_valid, redirect_pc); else n_pass++;
    n_checks++; if (upd_valid !== 1'b0) $display("FAIL wrap_no_enqueue got %0b exp 0", upd_valid); else n_pass++;
    cycle();
  endtask

  task automatic test_alias();
    upd_ready = 1'b1;
    drive(32'h500, 1'b0, 1'b0, 32'h0, 1'b1, 32'h900);
    cycle();
    idle();
    n_checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h504) $display("FAIL alias_redirect got %0b/%h exp 1/504", redirect_valid, redirect_pc); else n_pass++;
    n_checks++; if (upd_valid !== 1'b0) $display("FAIL alias_no_enqueue got %0b exp 0", upd_valid); else n_pass++;
    cycle();
    drive(32'h500, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    cycle();
    idle();
    n_checks++; if (redirect_valid !== 1'b0) $display("FAIL plain_no_redirect got %0b exp 0", redirect_valid); else n_pass++;
  endtask

  task automatic test_squash();
    upd_ready = 1'b0;
    drive(32'h400, 1'b1, 1'b1, 32'h500, 1'b0, 32'h0);
    cycle();
    drive(32'h600, 1'b1, 1'b1, 32'h700, 1'b0, 32'h0);
    cycle();
    idle();
    n_checks++; if (redirect_valid !== 1'b0) $display("FAIL squash_redirect got %0b exp 0", redirect_valid); else n_pass++;
    n_checks++; if (upd_valid !== 1'b1 || upd_pc !== 32'h400) $display("FAIL squash_head got %0b/%h exp 1/400", upd_valid, upd_pc); else n_pass++;
    upd_ready = 1'b1;
    cycle();
    n_checks++; if (upd_valid !== 1'b0) $display("FAIL squash_single_entry got upd_valid %0b exp 0", upd_valid); else n_pass++;
  endtask

  task automatic test_full_overflow();
    apply_reset();
    upd_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(32'h1000 + 32'(i * 16), 1'b1, 1'b1, 32'h2000 + 32'(i * 16), 1'b0, 32'h0);
      cycle();
      idle();
      if (i == 3) begin
        n_checks++; if (q_full !== 1'b1 || q_overflow !== 1'b0) $display("FAIL full_after4 got full %0b ovf %0b exp 1/0", q_full, q_overflow); else n_pass++;
      end
      if (i == 4) begin
        n_checks++; if (q_full !== 1'b1 || q_overflow !== 1'b1) $display("FAIL full_after5 got full %0b ovf %0b exp 1/1", q_full, q_overflow); else n_pass++;
      end
      cycle();
    end
    upd_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (upd_valid !== 1'b1 || upd_pc !== 32'h1000 + 32'(k * 16) || upd_target !== 32'h2000 + 32'(k * 16))
        $display("FAIL full_drain%0d got %0b %h/%h exp 1 %h/%h", k, upd_valid, upd_pc, upd_target,
                 32'h1000 + 32'(k * 16), 32'h2000 + 32'(k * 16));
      else n_pass++;
      cycle();
    end
    n_checks++; if (upd_valid !== 1'b0 || q_full !== 1'b0 || q_overflow !== 1'b1) $display("FAIL full_empty got v %0b full %0b ovf %0b exp 0/0/1", upd_valid, q_full, q_overflow); else n_pass++;
  endtask

  task automatic test_full_no_overflow();
    apply_reset();
    upd_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(32'h3000 + 32'(i * 8), 1'b1, 1'b1, 32'h4000 + 32'(i * 8), 1'b0, 32'h0);
      if (i == 4) upd_ready = 1'b1;
      cycle();
      idle();
      upd_ready = 1'b0;
      cycle();
    end
    n_checks++; if (q_overflow !== 1'b0 || q_full !== 1'b1) $display("FAIL nov_flags got ovf %0b full %0b exp 0/1", q_overflow, q_full); else n_pass++;
    upd_ready = 1'b1;
    for (int k = 1; k < 5; k++) begin
      n_checks++;
      if (upd_valid !== 1'b1 || upd_pc !== 32'h3000 + 32'(k * 8) || upd_target !== 32'h4000 + 32'(k * 8))
        $display("FAIL nov_drain%0d got %0b %h/%h exp 1 %h/%h", k, upd_valid, upd_pc, upd_target,
                 32'h3000 + 32'(k * 8), 32'h4000 + 32'(k * 8));
      else n_pass++;
      cycle();
    end
    n_checks++; if (upd_valid !== 1'b0) $display("FAIL nov_empty got %0b exp 0", upd_valid); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [CNT_WIDTH-1:0] exp_br, exp_mis;
    apply_reset();
    upd_ready = 1'b0;
    drive(32'h40, 1'b1, 1'b1, 32'h80, 1'b1, 32'h80);
    cycle();
    for (int i = 0; i < 3; i++) begin
      drive(32'h600 + 32'(i * 4), 1'b1, 1'b1, 32'h900 + 32'(i * 4), 1'b0, 32'h0);
      cycle();
      idle();
      if (i < 2) cycle();
    end
    exp_br  = PERF_EN ? CNT_WIDTH'(4) : '0;
    exp_mis = PERF_EN ? CNT_WIDTH'(3) : '0;
    n_checks++; if (br_count !== exp_br || mispred_count !== exp_mis) $display("FAIL mid_counts got %0d/%0d exp %0d/%0d", br_count, mispred_count, exp_br, exp_mis); else n_pass++;
    n_checks++; if (redirect_valid !== 1'b1 || upd_valid !== 1'b1) $display("FAIL mid_setup got rv %0b uv %0b exp 1/1", redirect_valid, upd_valid); else n_pass++;
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (redirect_valid !== 1'b0 || flush !== 1'b0 || redirect_pc !== 32'h0 || upd_valid !== 1'b0 ||
        q_full !== 1'b0 || q_overflow !== 1'b0 || br_count !== '0 || mispred_count !== '0)
      $display("FAIL mid_async_reset got rv %0b fl %0b rpc %h uv %0b full %0b ovf %0b br %0d mis %0d exp all 0",
               redirect_valid, flush, redirect_pc, upd_valid, q_full, q_overflow, br_count, mispred_count);
    else n_pass++;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    upd_ready = 1'b1;
    cycle();
    n_checks++; if (upd_valid !== 1'b0 || redirect_valid !== 1'b0) $display("FAIL mid_after_release got uv %0b rv %0b exp 0/0", upd_valid, redirect_valid); else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] tgt_pool [4];
    tgt_pool[0] = 32'h8000; tgt_pool[1] = 32'h8004; tgt_pool[2] = 32'h8100; tgt_pool[3] = 32'hFFFF_FFF0;
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      ex_valid       = ($urandom_range(0, 3) != 0);
      ex_pc          = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : 32'h1000 + 32'($urandom_range(0, 7) * 4);
      ex_is_branch   = ($urandom_range(0, 3) != 0);
      ex_taken       = $urandom_range(0, 1) == 1;
      ex_target      = tgt_pool[$urandom_range(0, 3)];
      ex_pred_hit    = $urandom_range(0, 1) == 1;
      ex_pred_target = tgt_pool[$urandom_range(0, 3)];
      upd_ready      = ($urandom_range(0, 2) == 0);
      cycle();
      n_checks++; if (redirect_valid !== m_rv || flush !== m_rv) $display("FAIL rnd_redirect c%0d got %0b/%0b exp %0b", c, redirect_valid, flush, m_rv); else n_pass++;
      if (m_rv) begin
        n_checks++; if (redirect_pc !== m_rpc) $display("FAIL rnd_redirect_pc c%0d got %h exp %h", c, redirect_pc, m_rpc); else n_pass++;
      end
      n_checks++; if (upd_valid !== (exp_q.size() != 0)) $display("FAIL rnd_upd_valid c%0d got %0b exp %0b", c, upd_valid, exp_q.size() != 0); else n_pass++;
      if (exp_q.size() != 0) begin
        n_checks++; if ({upd_pc, upd_target} !== exp_q[0]) $display("FAIL rnd_head c%0d got %h/%h exp %h", c, upd_pc, upd_target, exp_q[0]); else n_pass++;
      end
      n_checks++; if (q_full !== (exp_q.size() == QDEPTH) || q_overflow !== m_ovf) $display("FAIL rnd_flags c%0d got full %0b ovf %0b exp %0b/%0b", c, q_full, q_overflow, exp_q.size() == QDEPTH, m_ovf); else n_pass++;
      n_checks++; if (br_count !== m_br || mispred_count !== m_mis) $display("FAIL rnd_counts c%0d got %0d/%0d exp %0d/%0d", c, br_count, mispred_count, m_br, m_mis); else n_pass++;
    end
    idle();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_cold_miss();
    test_wrong_target();
    test_wrap();
    test_alias();
    test_squash();
    test_full_overflow();
    test_full_no_overflow();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
